// File: rtl/claw_if.sv
// Claw actuator signal bundle: catch request and limit switches in,
// motor drives, grip PWM and status out.
interface claw_if;
  logic [3:0] strength;
  logic       bottom_hit;
  logic       top_hit;
  logic       home_hit;
  logic       motor_down;
  logic       motor_up;
  logic       motor_back;
  logic       grip_pwm;
  logic       busy;
  logic       done;
  logic       fault;

  modport master (
    output strength, bottom_hit, top_hit, home_hit,
    input  motor_down, motor_up, motor_back,
    input  grip_pwm, busy, done, fault
  );

  modport slave (
    input  strength, bottom_hit, top_hit, home_hit,
    output motor_down, motor_up, motor_back,
    output grip_pwm, busy, done, fault
  );
endinterface

// File: rtl/claw_actuator.sv
// Claw catch sequencer: descend, grip, lift, return, release.
// Optional motion watchdog enabled by defining CLAW_TIMEOUT_EN.
module claw_actuator #(
  parameter int HOLD_CYC    = 64,
  parameter int RELEASE_CYC = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic   clk,
  input  logic   rstn,
  claw_if.slave  bus
);
  localparam int HR =
    HOLD_CYC > RELEASE_CYC ? HOLD_CYC : RELEASE_CYC;
`ifdef CLAW_TIMEOUT_EN
  localparam int MAXC = HR > TIMEOUT_CYC ? HR : TIMEOUT_CYC;
`else
  localparam int MAXC = HR;
`endif
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DESCEND, S_CLOSE,
    S_LIFT, S_RETURN, S_RELEASE
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    level, pwm_cnt, pwm_inc;
  logic          moving, counting;
  logic          md, mu, mb, grip, busy, done;

  assign moving = state inside {S_DESCEND, S_LIFT, S_RETURN};
`ifdef CLAW_TIMEOUT_EN
  logic to_hit, fault;
  assign counting = moving ||
    state inside {S_CLOSE, S_RELEASE};
`else
  assign counting = state inside {S_CLOSE, S_RELEASE};
`endif

  assign pwm_inc = (pwm_cnt == 4'd9) ? 4'd0 : pwm_cnt + 4'd1;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.strength != 4'd0) nxt = S_DESCEND;
      S_DESCEND:
        if (bus.bottom_hit) nxt = S_CLOSE;
      S_CLOSE:
        if (cnt == CW'(HOLD_CYC - 1)) nxt = S_LIFT;
      S_LIFT:
        if (bus.top_hit) nxt = S_RETURN;
      S_RETURN:
        if (bus.home_hit) nxt = S_RELEASE;
      S_RELEASE:
        if (cnt == CW'(RELEASE_CYC - 1)) nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
`ifdef CLAW_TIMEOUT_EN
    to_hit = 1'b0;
    // a limit switch seen in the same cycle wins over the watchdog
    if (moving && nxt == state &&
        cnt == CW'(TIMEOUT_CYC - 1)) begin
      nxt    = S_RELEASE;
      to_hit = 1'b1;
    end
`endif
    if (counting && nxt == state)
      cnt_nxt = cnt + CW'(1);
    else
      cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      level   <= 4'd0;
      pwm_cnt <= 4'd0;
      md      <= 1'b0;
      mu      <= 1'b0;
      mb      <= 1'b0;
      grip    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef CLAW_TIMEOUT_EN
      fault   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && nxt == S_DESCEND)
        level <= (bus.strength > 4'd9) ? 4'd9 : bus.strength;
      md   <= nxt == S_DESCEND;
      mu   <= nxt == S_LIFT;
      mb   <= nxt == S_RETURN;
      busy <= nxt != S_IDLE;
      done <= state == S_RELEASE && nxt == S_IDLE;
`ifdef CLAW_TIMEOUT_EN
      fault <= to_hit;
`endif
      // PWM phase restarts on CLOSE entry, runs on through LIFT/RETURN
      if (nxt == S_CLOSE && state != S_CLOSE) begin
        pwm_cnt <= 4'd0;
        grip    <= level != 4'd0;
      end else if (nxt inside {S_CLOSE, S_LIFT, S_RETURN}) begin
        pwm_cnt <= pwm_inc;
        grip    <= pwm_inc < level;
      end else begin
        pwm_cnt <= 4'd0;
        grip    <= 1'b0;
      end
    end
  end

  assign bus.motor_down = md;
  assign bus.motor_up   = mu;
  assign bus.motor_back = mb;
  assign bus.grip_pwm   = grip;
  assign bus.busy       = busy;
  assign bus.done       = done;
`ifdef CLAW_TIMEOUT_EN
  assign bus.fault      = fault;
`else
  assign bus.fault      = 1'b0;
`endif
endmodule

// File: doc/claw_actuator.md
CLAW_ACTUATOR -- requirements
Module: claw_actuator

Interface
REQ-001 Parameter: HOLD_CYC, default 64, number of cycles spent in CLOSE.
REQ-002 Parameter: RELEASE_CYC, default 32, number of cycles spent in RELEASE.
REQ-003 Parameter: TIMEOUT_CYC, default 1024, motion-state watchdog limit; used only with CLAW_TIMEOUT_EN.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 strength  input  4  one-cycle catch request from the coin FSM; nonzero value = start, value = grip level.
REQ-007 bottom_hit  input  1  lower limit switch, active-high.
REQ-008 top_hit  input  1  upper limit switch, active-high.
REQ-009 home_hit  input  1  chute-position limit switch, active-high.
REQ-010 motor_down  output  1  drive claw down.
REQ-011 motor_up  output  1  drive claw up.
REQ-012 motor_back  output  1  drive carriage to chute.
REQ-013 grip_pwm  output  1  grip coil PWM.
REQ-014 busy  output  1  high while a catch sequence is in progress.
REQ-015 done  output  1  one-cycle pulse at the end of a sequence.
REQ-016 fault  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 The states SHALL be IDLE, DESCEND, CLOSE, LIFT, RETURN and RELEASE; all outputs SHALL be registered Moore outputs, changing the cycle after the state change.
REQ-018 IDLE: strength!=0 at cycle N SHALL capture the level and enter DESCEND; busy=1 and motor_down=1 from N+1.
REQ-019 Captured level SHALL be min(strength,9); strength is ignored in every state other than IDLE.
REQ-020 DESCEND: motor_down=1; bottom_hit=1 SHALL move to CLOSE; if already high on entry, exit after one cycle.
REQ-021 CLOSE: motors off, PWM active, exactly HOLD_CYC cycles, then LIFT.
REQ-022 LIFT: motor_up=1, PWM active; top_hit SHALL move to RETURN.
REQ-023 RETURN: motor_back=1, PWM active; home_hit SHALL move to RELEASE.
REQ-024 RELEASE: motors off, grip_pwm=0, exactly RELEASE_CYC cycles, then IDLE with done=1 for one cycle and busy=0.
REQ-025 PWM: mod-10 counter cleared on CLOSE entry; grip_pwm=1 when counter < captured level (level 9 gives 9/10 duty).
REQ-026 At most one of motor_down/motor_up/motor_back SHALL be high in any cycle.
REQ-027 Limit inputs SHALL be ignored in states not listed above.
REQ-028 Count rule: zero-based counter compared against parameter minus 1; width = clog2 of the largest parameter.

Reset
REQ-029 rstn=0 SHALL force IDLE; all outputs, the counters and the captured level SHALL clear to 0 on the next edge, including mid-sequence.
REQ-030 A strength pulse coincident with rstn=0 SHALL be dropped.

Configuration
REQ-031 With CLAW_TIMEOUT_EN defined: a DESCEND, LIFT or RETURN residency of TIMEOUT_CYC cycles without its limit switch SHALL abort to RELEASE with fault=1 for one cycle, and done SHALL still pulse at the end of RELEASE.
REQ-032 Without CLAW_TIMEOUT_EN: there is no watchdog counter, fault is tied to 0, and motion states wait indefinitely.

Verification
REQ-033 strength=3 pulse, bottom_hit at +5, top_hit at +5 after LIFT entry, home_hit at +5 after RETURN entry -> full state walk; CLOSE lasts 64 cycles; grip_pwm 3 high / 7 low; done pulses once; busy falls the same cycle as done.
REQ-034 strength=12 -> grip duty 9/10; strength=5 pulse during LIFT -> ignored, no second sequence.
REQ-035 bottom_hit held high before the request -> DESCEND lasts exactly 1 cycle.
REQ-036 rstn=0 during LIFT -> next edge: all outputs 0 and state IDLE; a subsequent strength=1 starts a clean sequence.
REQ-037 CLAW_TIMEOUT_EN, TIMEOUT_CYC=16, bottom_hit never asserted -> fault pulse after 16 DESCEND cycles, then 32 RELEASE cycles and a done pulse; without the macro, DESCEND persists and fault stays 0.
REQ-038 Every cycle of all scenarios -> the one-hot motor assertion holds.
